// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions for the board link (rx and tx sides).
//   - UART_DATA_BITS    : payload bits per frame (8N1)
//   - UART_CLKS_PER_BIT : default bit period in clock cycles (50 MHz / 115200)
//   - rx_state_t        : receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Multi-flop synchroniser bringing the asynchronous serial pin into the
//   receiver clock domain. Flops reset to 1 so that reset never looks like the
//   falling edge of a start bit.
// Ports:
//   i_clk  : receiver clock
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous input (idle high)
//   o_q    : synchronised output, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. Samples each bit mid-period using a clock counter,
//   LSB first, and presents each byte on a valid/ready holding register.
//   Flags a bad stop bit (framing error) and a byte lost to a full holding
//   register (overrun) as single-cycle pulses.
// Ports:
//   i_rx_clk       : clock, all logic on posedge
//   i_rx_rst       : synchronous active-high reset
//   i_rx_line      : asynchronous serial input, idle high
//   o_rx_data      : received byte, stable while o_rx_valid
//   o_rx_valid     : byte available, held until accepted
//   i_rx_ready     : consumer accepts byte when valid && ready
//   o_rx_frame_err : 1-cycle pulse, stop bit sampled low
//   o_rx_overrun   : 1-cycle pulse, completed byte dropped (holding reg full)
//   o_rx_busy      : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      i_rx_clk,
  input  logic                      i_rx_rst,
  input  logic                      i_rx_line,
  output logic [UART_DATA_BITS-1:0] o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  output logic                      o_rx_frame_err,
  output logic                      o_rx_overrun,
  output logic                      o_rx_busy
);

  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LP_LAST = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  rx_state_t                 r_state;
  rx_state_t                 w_state_nxt;
  logic [15:0]               r_clk_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_overrun;
  logic                      w_bit_tick;
  logic                      w_stop_ok;
  logic                      w_stop_bad;
  logic                      w_hold_full;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_rx_clk),
    .i_rst (i_rx_rst),
    .i_d   (i_rx_line),
    .o_q   (w_rx_s)
  );

  // Next-state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_bit_tick  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      RX_IDLE:  if (!w_rx_s) w_state_nxt = RX_START;
      // Mid-start-bit check rejects short glitches without flagging anything
      RX_START: if (r_clk_cnt == LP_HALF) w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (r_clk_cnt == LP_FULL) begin
          w_bit_tick = 1'b1;
          if (r_bit_idx == LP_LAST) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == LP_FULL) begin
          if (w_rx_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = RX_BREAK;
          end
        end
      end
      // A held-low line must not be mistaken for a new start bit
      RX_BREAK: if (w_rx_s) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) r_state <= RX_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Bit-period counter: restarts on every state change and every data bit
  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst)
      r_clk_cnt <= '0;
    else if (w_state_nxt != r_state || w_bit_tick)
      r_clk_cnt <= '0;
    else if (r_state != RX_IDLE && r_state != RX_BREAK)
      r_clk_cnt <= r_clk_cnt + 16'd1;
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) begin
      r_bit_idx <= '0;
      r_shreg   <= '0;
    end else begin
      if (r_state != RX_DATA) r_bit_idx <= '0;
      else if (w_bit_tick)    r_bit_idx <= r_bit_idx + 3'd1;
      if (w_bit_tick) r_shreg[r_bit_idx] <= w_rx_s;
    end
  end

  // Holding register: a byte still waiting with no acceptance this cycle
  // wins over the newly completed one.
  assign w_hold_full = r_valid && !i_rx_ready;

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_ok && w_hold_full;
      if (w_stop_ok && !w_hold_full) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && i_rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data      = r_data;
  assign o_rx_valid     = r_valid;
  assign o_rx_frame_err = r_frame_err;
  assign o_rx_overrun   = r_overrun;
  assign o_rx_busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx. One instance at 16 clocks/bit for the
//   functional scenarios, one at 434 clocks/bit for baud tolerance. A simple
//   transmitter task drives the serial lines at negedge; outputs are observed
//   at negedge by a monitor that counts events.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       line16, line434, rdy16;
  logic [7:0] d16_data, d4_data;
  logic       d16_valid, d16_ferr, d16_ovr, d16_busy;
  logic       d4_valid, d4_ferr, d4_ovr, d4_busy;

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .i_rx_clk       (clk),
    .i_rx_rst       (rst),
    .i_rx_line      (line16),
    .o_rx_data      (d16_data),
    .o_rx_valid     (d16_valid),
    .i_rx_ready     (rdy16),
    .o_rx_frame_err (d16_ferr),
    .o_rx_overrun   (d16_ovr),
    .o_rx_busy      (d16_busy)
  );

  uart_rx #(.CLKS_PER_BIT(434), .SYNC_STAGES(2)) dut434 (
    .i_rx_clk       (clk),
    .i_rx_rst       (rst),
    .i_rx_line      (line434),
    .o_rx_data      (d4_data),
    .o_rx_valid     (d4_valid),
    .i_rx_ready     (1'b1),
    .o_rx_frame_err (d4_ferr),
    .o_rx_overrun   (d4_ovr),
    .o_rx_busy      (d4_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event monitor
  int         v16_cnt = 0, fe16 = 0, ov16 = 0, both16 = 0, v16_rise_cyc = 0;
  logic [7:0] last16 = 8'h00;
  logic       pv16 = 1'b0;
  int         fe4 = 0, ov4 = 0;
  logic [7:0] q4[$];
  int         t_fall = 0;

  always @(negedge clk) begin
    if (d16_valid) begin
      v16_cnt++;
      last16 = d16_data;
    end
    if (d16_valid && !pv16) v16_rise_cyc = cyc;
    pv16 = d16_valid;
    if (d16_ferr) fe16++;
    if (d16_ovr)  ov16++;
    if (d16_ferr && d16_ovr) both16++;
    if (d4_valid) q4.push_back(d4_data);
    if (d4_ferr) fe4++;
    if (d4_ovr)  ov4++;
  end

  task automatic set_line(input bit big, input logic v);
    if (big) line434 = v;
    else     line16  = v;
  endtask

  // Model transmitter: start, 8 data LSB first, stop; bc clocks per bit
  task automatic tx(input logic [7:0] b, input logic stop_v, input int bc, input bit big);
    if (!big) t_fall = cyc;
    set_line(big, 1'b0);
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(big, b[i]);
      repeat (bc) @(negedge clk);
    end
    set_line(big, stop_v);
    repeat (bc) @(negedge clk);
    set_line(big, 1'b1);
  endtask

  task automatic test_reset;
    n_cmp++; if (d16_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h want 00", d16_data); end
    n_cmp++; if (d16_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", d16_valid); end
    n_cmp++; if (d16_ferr !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", d16_ferr); end
    n_cmp++; if (d16_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", d16_ovr); end
    n_cmp++; if (d16_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", d16_busy); end
    n_cmp++; if (d4_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy434: got %b want 0", d4_busy); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int v0 = v16_cnt, f0 = fe16, o0 = ov16, lat;
    rdy16 = 1'b1;
    tx(8'h41, 1'b1, 16, 1'b0);
    repeat (32) @(negedge clk);
    lat = v16_rise_cyc - t_fall;
    n_cmp++; if (v16_cnt - v0 != 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d want 1", v16_cnt - v0); end
    n_cmp++; if (last16 !== 8'h41) begin n_bad++; $display("FAIL single_data: got %0h want 41", last16); end
    n_cmp++; if (fe16 - f0 != 0) begin n_bad++; $display("FAIL single_ferr: got %0d want 0", fe16 - f0); end
    n_cmp++; if (ov16 - o0 != 0) begin n_bad++; $display("FAIL single_ovr: got %0d want 0", ov16 - o0); end
    n_cmp++; if (lat < 154 || lat > 156) begin n_bad++; $display("FAIL single_latency: got %0d want 155+/-1", lat); end
  endtask

  task automatic test_overrun;
    int f0 = fe16, o0 = ov16;
    rdy16 = 1'b0;
    tx(8'h41, 1'b1, 16, 1'b0);
    tx(8'h42, 1'b1, 16, 1'b0);
    tx(8'h43, 1'b1, 16, 1'b0);
    tx(8'h44, 1'b1, 16, 1'b0);
    repeat (32) @(negedge clk);
    n_cmp++; if (d16_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_held: got %b want 1", d16_valid); end
    n_cmp++; if (d16_data !== 8'h41) begin n_bad++; $display("FAIL ovr_data: got %0h want 41", d16_data); end
    n_cmp++; if (ov16 - o0 != 3) begin n_bad++; $display("FAIL ovr_count: got %0d want 3", ov16 - o0); end
    n_cmp++; if (fe16 - f0 != 0) begin n_bad++; $display("FAIL ovr_ferr: got %0d want 0", fe16 - f0); end
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
    n_cmp++; if (d16_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop: got %b want 0", d16_valid); end
    n_cmp++; if (d16_data !== 8'h41) begin n_bad++; $display("FAIL ovr_data_kept: got %0h want 41", d16_data); end
    rdy16 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_err;
    int v0 = v16_cnt, f0 = fe16, o0 = ov16;
    rdy16 = 1'b1;
    tx(8'h55, 1'b0, 16, 1'b0);
    line16 = 1'b0;
    repeat (80) @(negedge clk);
    n_cmp++; if (fe16 - f0 != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", fe16 - f0); end
    n_cmp++; if (v16_cnt - v0 != 0) begin n_bad++; $display("FAIL ferr_valid: got %0d want 0", v16_cnt - v0); end
    n_cmp++; if (d16_busy !== 1'b1) begin n_bad++; $display("FAIL ferr_break_busy: got %b want 1", d16_busy); end
    line16 = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (d16_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_idle_after: got %b want 0", d16_busy); end
    tx(8'hA5, 1'b1, 16, 1'b0);
    repeat (32) @(negedge clk);
    n_cmp++; if (last16 !== 8'hA5) begin n_bad++; $display("FAIL ferr_next_data: got %0h want a5", last16); end
    n_cmp++; if (v16_cnt - v0 != 1) begin n_bad++; $display("FAIL ferr_next_valid: got %0d want 1", v16_cnt - v0); end
    n_cmp++; if (fe16 - f0 != 1) begin n_bad++; $display("FAIL ferr_once: got %0d want 1", fe16 - f0); end
    n_cmp++; if (ov16 - o0 != 0) begin n_bad++; $display("FAIL ferr_ovr: got %0d want 0", ov16 - o0); end
  endtask

  task automatic test_glitch;
    int v0 = v16_cnt, f0 = fe16, o0 = ov16;
    line16 = 1'b0;
    repeat (3) @(negedge clk);
    line16 = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (d16_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got %b want 1", d16_busy); end
    repeat (30) @(negedge clk);
    n_cmp++; if (d16_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", d16_busy); end
    n_cmp++; if (v16_cnt - v0 != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", v16_cnt - v0); end
    n_cmp++; if ((fe16 - f0) + (ov16 - o0) != 0) begin n_bad++; $display("FAIL glitch_flags: got %0d want 0", (fe16 - f0) + (ov16 - o0)); end
  endtask

  task automatic test_reset_mid;
    int v0 = v16_cnt, f0 = fe16;
    rdy16 = 1'b1;
    fork
      tx(8'hFF, 1'b1, 16, 1'b0);
      begin
        repeat (60) @(negedge clk);
        n_cmp++; if (d16_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", d16_busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (d16_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %0h want 00", d16_data); end
        n_cmp++; if (d16_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", d16_busy); end
        n_cmp++; if ({d16_valid, d16_ferr, d16_ovr} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {d16_valid, d16_ferr, d16_ovr}); end
        rst = 1'b0;
      end
    join
    repeat (32) @(negedge clk);
    n_cmp++; if ((v16_cnt - v0) + (fe16 - f0) != 0) begin n_bad++; $display("FAIL rstmid_abort_events: got %0d want 0", (v16_cnt - v0) + (fe16 - f0)); end
    tx(8'h00, 1'b1, 16, 1'b0);
    repeat (32) @(negedge clk);
    n_cmp++; if (v16_cnt - v0 != 1) begin n_bad++; $display("FAIL rstmid_next_valid: got %0d want 1", v16_cnt - v0); end
    n_cmp++; if (last16 !== 8'h00) begin n_bad++; $display("FAIL rstmid_next_data: got %0h want 00", last16); end
    n_cmp++; if (fe16 - f0 != 0) begin n_bad++; $display("FAIL rstmid_next_ferr: got %0d want 0", fe16 - f0); end
  endtask

  task automatic test_baud;
    int f0 = fe4, o0 = ov4;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h5A;
    q4.delete();
    tx(8'h00, 1'b1, 442, 1'b1);   // ~2% slow
    tx(8'hFF, 1'b1, 426, 1'b1);   // ~2% fast
    tx(8'h5A, 1'b1, 442, 1'b1);
    repeat (600) @(negedge clk);
    n_cmp++; if (q4.size() != 3) begin n_bad++; $display("FAIL baud_count: got %0d want 3", q4.size()); end
    for (int i = 0; i < 3; i++) begin
      if (q4.size() > i) begin
        n_cmp++; if (q4[i] !== exp_b[i]) begin n_bad++; $display("FAIL baud_byte%0d: got %0h want %0h", i, q4[i], exp_b[i]); end
      end
    end
    n_cmp++; if ((fe4 - f0) + (ov4 - o0) != 0) begin n_bad++; $display("FAIL baud_flags: got %0d want 0", (fe4 - f0) + (ov4 - o0)); end
  endtask

  initial begin
    rst     = 1'b1;
    line16  = 1'b1;
    line434 = 1'b1;
    rdy16   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_single;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    test_baud;
    n_cmp++; if (both16 != 0) begin n_bad++; $display("FAIL ferr_ovr_same_cycle: got %0d want 0", both16); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
